i2c_arbiter: RTL

Two-client arbiter that shares one `i2c_master` command port between independent requesters, for example `read_eeprom` and a future EEPROM writer or sensor poller. It sits between the requesters and `i2c_master`, in the same clock domain as `i2c_master`. It grants the bus round-robin, holds the grant for one complete transaction, and routes the byte handshakes only to the granted client. It reports completion or a start timeout to that client.

---
 rtl/i2c_pkg.sv | 16 +
 rtl/i2c_arbiter_if.sv | 25 ++
 rtl/i2c_arbiter.sv | 122 ++++++++++++
 3 files changed

// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared I2C widths, arbiter state and client index types
package i2c_pkg;

    localparam int ADDR_W = 7;
    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT_BUSY,
        ACTIVE
    } arb_state_t;

    typedef logic client_t;

endpackage

// File: rtl/i2c_arbiter_if.sv
// rtl/i2c_arbiter_if.sv - command/handshake bundle between the arbiter and i2c_master
interface i2c_arbiter_if;
    import i2c_pkg::*;

    logic              i2c_start;
    logic [BYTE_W-1:0] i2c_nbytes;
    logic [ADDR_W-1:0] i2c_addr;
    logic              i2c_rw;
    logic [BYTE_W-1:0] i2c_write_data;
    logic [BYTE_W-1:0] i2c_read_data;
    logic              i2c_tx_data_req;
    logic              i2c_rx_data_ready;
    logic              i2c_busy;

    modport master (
        output i2c_start, i2c_nbytes, i2c_addr, i2c_rw, i2c_write_data,
        input  i2c_read_data, i2c_tx_data_req, i2c_rx_data_ready, i2c_busy
    );

    modport slave (
        input  i2c_start, i2c_nbytes, i2c_addr, i2c_rw, i2c_write_data,
        output i2c_read_data, i2c_tx_data_req, i2c_rx_data_ready, i2c_busy
    );

endinterface

// File: rtl/i2c_arbiter.sv
// rtl/i2c_arbiter.sv - two-client round-robin arbiter in front of one i2c_master
module i2c_arbiter
    import i2c_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int TO_W           = 11
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        req,
    input  logic [BYTE_W-1:0] nbytes0,
    input  logic [BYTE_W-1:0] nbytes1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic              rw0,
    input  logic              rw1,
    input  logic [BYTE_W-1:0] wdata0,
    input  logic [BYTE_W-1:0] wdata1,
    output logic [1:0]        grant,
    output logic [1:0]        done,
    output logic [1:0]        err,
    output logic [1:0]        tx_req,
    output logic [1:0]        rx_rdy,
    output logic [BYTE_W-1:0] rdata,
    i2c_arbiter_if.master     bus
);

    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYCLES);

    arb_state_t      state, state_nxt;
    client_t         owner, owner_nxt;
    client_t         last_owner, last_nxt;
    logic [TO_W-1:0] cnt, cnt_nxt, cnt_inc;
    logic [1:0]      done_nxt, err_nxt;

    // On contention the previous owner yields to its peer.
    function automatic client_t rr_pick(input logic [1:0] r, input client_t last);
        if (r == 2'b11) return ~last;
        else if (r[0])  return 1'b0;
        else            return 1'b1;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_owner <= 1'b1;
            cnt        <= '0;
            done       <= '0;
            err        <= '0;
        end else begin
            state      <= state_nxt;
            owner      <= owner_nxt;
            last_owner <= last_nxt;
            cnt        <= cnt_nxt;
            done       <= done_nxt;
            err        <= err_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        last_nxt  = last_owner;
        cnt_nxt   = cnt;
        done_nxt  = '0;
        err_nxt   = '0;
        cnt_inc   = (cnt == TO_LIMIT) ? cnt : cnt + TO_W'(1);
        case (state)
            IDLE: begin
                if (req != 2'b00 && !bus.i2c_busy) begin
                    owner_nxt = rr_pick(req, last_owner);
                    state_nxt = START;
                end
            end
            START: begin
                cnt_nxt   = '0;
                state_nxt = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (bus.i2c_busy) begin
                    state_nxt = ACTIVE;
                end else begin
                    cnt_nxt = cnt_inc;
                    if (cnt_inc == TO_LIMIT) begin
                        err_nxt[owner] = 1'b1;
                        last_nxt       = owner;
                        state_nxt      = IDLE;
                    end
                end
            end
            ACTIVE: begin
                if (!bus.i2c_busy) begin
                    done_nxt[owner] = 1'b1;
                    last_nxt        = owner;
                    state_nxt       = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign grant         = (state == IDLE) ? 2'b00 : (owner ? 2'b10 : 2'b01);
    assign bus.i2c_start = (state == START);
    assign tx_req        = grant & {2{bus.i2c_tx_data_req}};
    assign rx_rdy        = grant & {2{bus.i2c_rx_data_ready}};
    assign rdata         = bus.i2c_read_data;

    always_comb begin
        bus.i2c_nbytes     = '0;
        bus.i2c_addr       = '0;
        bus.i2c_rw         = 1'b0;
        bus.i2c_write_data = '0;
        if (grant != 2'b00) begin
            bus.i2c_nbytes     = owner ? nbytes1 : nbytes0;
            bus.i2c_addr       = owner ? addr1   : addr0;
            bus.i2c_rw         = owner ? rw1     : rw0;
            bus.i2c_write_data = owner ? wdata1  : wdata0;
        end
    end

endmodule
